// File: rtl/gpr_wb_queue_pkg.sv
// Shared constants for the GPR write-back queue: register-file enable polarity
// and default bus widths.
package gpr_wb_queue_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int REG_ADDR_W  = 5;
  localparam int WORD_DATA_W = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Two-push / one-pop circular buffer. Lane 0 lands first, lane 1 directly behind it.
// Per-entry valid and address vectors are exported for the pending-write scoreboard.
module gpr_wb_fifo
  import gpr_wb_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_DATA_W,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic                           i_push0,
  input  logic [ADDR_W-1:0]              i_addr0,
  input  logic [DATA_W-1:0]              i_data0,
  input  logic                           i_push1,
  input  logic [ADDR_W-1:0]              i_addr1,
  input  logic [DATA_W-1:0]              i_data1,
  input  logic                           i_pop,
  output logic [ADDR_W-1:0]              o_head_addr,
  output logic [DATA_W-1:0]              o_head_data,
  output logic [CNT_W-1:0]               o_count,
  output logic [DEPTH-1:0]               o_ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_wptr;
  logic [PTR_W-1:0]             r_rptr;
  logic [CNT_W-1:0]             r_count;

  logic [PTR_W-1:0] w_slot1;

  // Lane 1 takes the slot after lane 0 only when lane 0 actually pushes.
  assign w_slot1 = r_wptr + PTR_W'(i_push0);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_vld   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PTR_W'(1);
      end
      if (i_push0) begin
        r_vld[r_wptr]  <= 1'b1;
        r_addr[r_wptr] <= i_addr0;
        r_data[r_wptr] <= i_data0;
      end
      if (i_push1) begin
        r_vld[w_slot1]  <= 1'b1;
        r_addr[w_slot1] <= i_addr1;
        r_data[w_slot1] <= i_data1;
      end
      r_wptr  <= r_wptr + PTR_W'(i_push0) + PTR_W'(i_push1);
      r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
    end
  end

  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign o_ent_vld   = r_vld;
  assign o_ent_addr  = r_addr;

endmodule

// File: rtl/gpr_wb_queue.sv
// Write-back queue in front of the GPR file's single active-low write port.
// Accepts Mem (older) and Ex results, drains one per cycle, and answers busy queries for decode.
module gpr_wb_queue
  import gpr_wb_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     MemValid,
  output logic                     MemReady,
  input  logic [ADDR_W-1:0]        MemAddr,
  input  logic [DATA_W-1:0]        MemData,
  input  logic                     ExValid,
  output logic                     ExReady,
  input  logic [ADDR_W-1:0]        ExAddr,
  input  logic [DATA_W-1:0]        ExData,
  output logic                     WE_,
  output logic [ADDR_W-1:0]        WrAddr,
  output logic [DATA_W-1:0]        WrData,
  input  logic [ADDR_W-1:0]        QryAddr0,
  output logic                     QryBusy0,
  input  logic [ADDR_W-1:0]        QryAddr1,
  output logic                     QryBusy1,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]             w_count;
  logic [CNT_W-1:0]             w_free;
  logic                         w_empty;
  logic                         w_mem_push;
  logic                         w_ex_push;
  logic [ADDR_W-1:0]            w_head_addr;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0]             w_ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_addr;

  // Space is judged on the registered count only; this cycle's pop frees nothing yet.
  assign w_free     = CNT_W'(DEPTH) - w_count;
  assign w_empty    = (w_count == '0);
  assign MemReady   = (w_free >= CNT_W'(1));
  assign ExReady    = MemValid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));
  assign w_mem_push = MemValid & MemReady;
  assign w_ex_push  = ExValid & ExReady;

  gpr_wb_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset_     (reset_),
    .i_push0    (w_mem_push),
    .i_addr0    (MemAddr),
    .i_data0    (MemData),
    .i_push1    (w_ex_push),
    .i_addr1    (ExAddr),
    .i_data1    (ExData),
    .i_pop      (!w_empty),
    .o_head_addr(w_head_addr),
    .o_head_data(w_head_data),
    .o_count    (w_count),
    .o_ent_vld  (w_ent_vld),
    .o_ent_addr (w_ent_addr)
  );

  assign WE_    = w_empty ? DISABLE_ : ENABLE_;
  assign WrAddr = w_empty ? '0 : w_head_addr;
  assign WrData = w_empty ? '0 : w_head_data;
  assign Count  = w_count;

  always_comb begin
    QryBusy0 = 1'b0;
    QryBusy1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_addr[i] == QryAddr0)) QryBusy0 = 1'b1;
      if (w_ent_vld[i] && (w_ent_addr[i] == QryAddr1)) QryBusy1 = 1'b1;
    end
  end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed bench for gpr_wb_queue: reset, single push, same-destination pair,
// readiness near capacity, FIFO order against a queue model, mid-run reset, scoreboard.
module tb_gpr_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          MemValid = 1'b0, ExValid = 1'b0;
  logic          MemReady, ExReady;
  logic [AW-1:0] MemAddr = '0, ExAddr = '0, QryAddr0 = '0, QryAddr1 = '0;
  logic [DW-1:0] MemData = '0, ExData = '0;
  logic          WE_, QryBusy0, QryBusy1;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic [2:0]    Count;

  int total = 0;
  int bad = 0;

  gpr_wb_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_(reset_),
    .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
    .ExValid(ExValid), .ExReady(ExReady), .ExAddr(ExAddr), .ExData(ExData),
    .WE_(WE_), .WrAddr(WrAddr), .WrData(WrData),
    .QryAddr0(QryAddr0), .QryBusy0(QryBusy0), .QryAddr1(QryAddr1), .QryBusy1(QryBusy1),
    .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({WE_, WrAddr, WrData, Count, QryBusy0, QryBusy1} !== {1'b1, 5'd0, 32'd0, 3'd0, 2'b00}) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", {WE_, WrAddr, WrData, Count, QryBusy0, QryBusy1}, {1'b1, 5'd0, 32'd0, 3'd0, 2'b00});
    end
    step; step;
    reset_ = 1'b1;
    step;
    total++;
    if ({WE_, WrAddr, WrData, Count, QryBusy0, QryBusy1} !== {1'b1, 5'd0, 32'd0, 3'd0, 2'b00}) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", {WE_, WrAddr, WrData, Count, QryBusy0, QryBusy1}, {1'b1, 5'd0, 32'd0, 3'd0, 2'b00});
    end
  endtask

  task automatic test_single_ex;
    ExValid = 1'b1; ExAddr = 5'd3; ExData = 32'h1234_5678;
    #1;
    total++;
    if ({MemReady, ExReady} !== 2'b11) begin
      bad++; $display("FAIL single_ready got=%b want=11", {MemReady, ExReady});
    end
    step;
    ExValid = 1'b0;
    total++;
    if ({WE_, WrAddr, WrData, Count} !== {1'b0, 5'd3, 32'h1234_5678, 3'd1}) begin
      bad++; $display("FAIL single_write got=%h want=%h", {WE_, WrAddr, WrData, Count}, {1'b0, 5'd3, 32'h1234_5678, 3'd1});
    end
    step;
    total++;
    if ({WE_, WrAddr, WrData, Count} !== {1'b1, 5'd0, 32'd0, 3'd0}) begin
      bad++; $display("FAIL single_after got=%h want=%h", {WE_, WrAddr, WrData, Count}, {1'b1, 5'd0, 32'd0, 3'd0});
    end
  endtask

  task automatic test_same_dest;
    MemValid = 1'b1; MemAddr = 5'd5; MemData = 32'hA;
    ExValid = 1'b1; ExAddr = 5'd5; ExData = 32'hB;
    QryAddr0 = 5'd5;
    #1;
    total++;
    if ({MemReady, ExReady, QryBusy0} !== 3'b110) begin
      bad++; $display("FAIL same_ready got=%b want=110", {MemReady, ExReady, QryBusy0});
    end
    step;
    MemValid = 1'b0; ExValid = 1'b0;
    total++;
    if ({WE_, WrAddr, WrData, Count, QryBusy0} !== {1'b0, 5'd5, 32'hA, 3'd2, 1'b1}) begin
      bad++; $display("FAIL same_first got=%h want=%h", {WE_, WrAddr, WrData, Count, QryBusy0}, {1'b0, 5'd5, 32'hA, 3'd2, 1'b1});
    end
    step;
    total++;
    if ({WE_, WrAddr, WrData, Count, QryBusy0} !== {1'b0, 5'd5, 32'hB, 3'd1, 1'b1}) begin
      bad++; $display("FAIL same_second got=%h want=%h", {WE_, WrAddr, WrData, Count, QryBusy0}, {1'b0, 5'd5, 32'hB, 3'd1, 1'b1});
    end
    step;
    total++;
    if ({WE_, WrAddr, WrData, Count, QryBusy0} !== {1'b1, 5'd0, 32'd0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL same_after got=%h want=%h", {WE_, WrAddr, WrData, Count, QryBusy0}, {1'b1, 5'd0, 32'd0, 3'd0, 1'b0});
    end
  endtask

  // With the write port draining every cycle the queue peaks at three entries.
  task automatic test_back_to_back;
    MemValid = 1'b1; MemAddr = 5'd1; MemData = 32'h11;
    ExValid = 1'b1; ExAddr = 5'd2; ExData = 32'h22;
    step;
    MemAddr = 5'd3; MemData = 32'h33; ExAddr = 5'd4; ExData = 32'h44;
    #1;
    total++;
    if ({MemReady, ExReady, Count} !== {2'b11, 3'd2}) begin
      bad++; $display("FAIL b2b_cnt2 got=%b want=%b", {MemReady, ExReady, Count}, {2'b11, 3'd2});
    end
    step;
    MemAddr = 5'd5; MemData = 32'h55; ExAddr = 5'd6; ExData = 32'h66;
    #1;
    total++;
    if ({MemReady, ExReady, Count, WrAddr} !== {2'b10, 3'd3, 5'd2}) begin
      bad++; $display("FAIL b2b_cnt3_both got=%b want=%b", {MemReady, ExReady, Count, WrAddr}, {2'b10, 3'd3, 5'd2});
    end
    step;
    MemValid = 1'b0;
    #1;
    total++;
    if ({ExReady, Count, WrAddr} !== {1'b1, 3'd3, 5'd3}) begin
      bad++; $display("FAIL b2b_cnt3_ex got=%b want=%b", {ExReady, Count, WrAddr}, {1'b1, 3'd3, 5'd3});
    end
    step;
    ExValid = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      total++;
      if ({WE_, WrAddr, WrData} !== {1'b0, 5'(i), 32'(i * 17)}) begin
        bad++; $display("FAIL b2b_drain got=%h want=%h", {WE_, WrAddr, WrData}, {1'b0, 5'(i), 32'(i * 17)});
      end
      step;
    end
    total++;
    if ({WE_, Count} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL b2b_empty got=%b want=1000", {WE_, Count});
    end
  endtask

  task automatic test_fifo_order;
    logic [AW+DW-1:0] q[$];
    logic [AW+DW-1:0] exp_ad;
    int sent = 0;
    int free;
    logic exp_mr, exp_er, mem_acc, ex_acc, done;
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      exp_ad = (q.size() != 0) ? q[0] : '0;
      total++;
      if ({WE_, WrAddr, WrData, Count} !== {(q.size() == 0), exp_ad, 3'(q.size())}) begin
        bad++; $display("FAIL order_port got=%h want=%h", {WE_, WrAddr, WrData, Count}, {(q.size() == 0), exp_ad, 3'(q.size())});
      end
      if (!MemValid && sent < 20 && $urandom_range(0, 1) == 1) begin
        MemValid = 1'b1; MemAddr = 5'($urandom); MemData = $urandom; sent++;
      end
      if (!ExValid && sent < 20 && $urandom_range(0, 1) == 1) begin
        ExValid = 1'b1; ExAddr = 5'($urandom); ExData = $urandom; sent++;
      end
      #1;
      free = DEPTH - q.size();
      exp_mr = (free >= 1);
      exp_er = MemValid ? (free >= 2) : (free >= 1);
      total++;
      if ({MemReady, ExReady} !== {exp_mr, exp_er}) begin
        bad++; $display("FAIL order_ready got=%b want=%b", {MemReady, ExReady}, {exp_mr, exp_er});
      end
      mem_acc = MemValid && exp_mr;
      ex_acc = ExValid && exp_er;
      if (q.size() != 0) void'(q.pop_front());
      if (mem_acc) q.push_back({MemAddr, MemData});
      if (ex_acc) q.push_back({ExAddr, ExData});
      step;
      if (mem_acc) MemValid = 1'b0;
      if (ex_acc) ExValid = 1'b0;
      done = (sent == 20) && !MemValid && !ExValid && (q.size() == 0);
    end
    total++;
    if (!done || WE_ !== 1'b1) begin
      bad++; $display("FAIL order_timeout got=done%0d we%b want=done1 we1", done, WE_);
    end
  endtask

  task automatic test_reset_mid;
    MemValid = 1'b1; MemAddr = 5'd1; ExValid = 1'b1; ExAddr = 5'd2;
    step;
    MemAddr = 5'd3; ExAddr = 5'd4;
    step;
    MemValid = 1'b0; ExValid = 1'b0;
    QryAddr0 = 5'd3; QryAddr1 = 5'd4;
    #1;
    total++;
    if ({WE_, Count, QryBusy0, QryBusy1} !== {1'b0, 3'd3, 2'b11}) begin
      bad++; $display("FAIL rstmid_pre got=%b want=%b", {WE_, Count, QryBusy0, QryBusy1}, {1'b0, 3'd3, 2'b11});
    end
    reset_ = 1'b0;
    #1;
    total++;
    if ({WE_, WrAddr, Count, QryBusy0, QryBusy1} !== {1'b1, 5'd0, 3'd0, 2'b00}) begin
      bad++; $display("FAIL rstmid_assert got=%b want=%b", {WE_, WrAddr, Count, QryBusy0, QryBusy1}, {1'b1, 5'd0, 3'd0, 2'b00});
    end
    step;
    reset_ = 1'b1;
    step;
    total++;
    if ({WE_, Count, QryBusy0, QryBusy1} !== {1'b1, 3'd0, 2'b00}) begin
      bad++; $display("FAIL rstmid_release got=%b want=%b", {WE_, Count, QryBusy0, QryBusy1}, {1'b1, 3'd0, 2'b00});
    end
  endtask

  task automatic test_scoreboard;
    MemValid = 1'b1; MemAddr = 5'd7; MemData = 32'h70;
    ExValid = 1'b1; ExAddr = 5'd9; ExData = 32'h90;
    QryAddr0 = 5'd7; QryAddr1 = 5'd9;
    #1;
    total++;
    if ({QryBusy0, QryBusy1} !== 2'b00) begin
      bad++; $display("FAIL sb_not_yet got=%b want=00", {QryBusy0, QryBusy1});
    end
    step;
    MemValid = 1'b0; ExValid = 1'b0;
    total++;
    if ({QryBusy0, QryBusy1, WrAddr} !== {2'b11, 5'd7}) begin
      bad++; $display("FAIL sb_both got=%b want=%b", {QryBusy0, QryBusy1, WrAddr}, {2'b11, 5'd7});
    end
    QryAddr0 = 5'd8;
    #1;
    total++;
    if ({QryBusy0, QryBusy1} !== 2'b01) begin
      bad++; $display("FAIL sb_r8 got=%b want=01", {QryBusy0, QryBusy1});
    end
    QryAddr0 = 5'd7;
    step;
    total++;
    if ({QryBusy0, QryBusy1, WrAddr} !== {2'b01, 5'd9}) begin
      bad++; $display("FAIL sb_r7_clear got=%b want=%b", {QryBusy0, QryBusy1, WrAddr}, {2'b01, 5'd9});
    end
    step;
    total++;
    if ({QryBusy0, QryBusy1, WE_} !== 3'b001) begin
      bad++; $display("FAIL sb_r9_clear got=%b want=001", {QryBusy0, QryBusy1, WE_});
    end
  endtask

  initial begin
    test_reset;
    test_single_ex;
    test_same_dest;
    test_back_to_back;
    test_fifo_order;
    test_reset_mid;
    test_scoreboard;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
